mat_result_unloader: RTL and testbench

- Reads the complex MATRIX_DIM x MATRIX_DIM result matrix out of the result RAM and streams it as single words over a valid/ready interface.
- It is the read-out counterpart of the matrix load sequence: all real words are sent first (address 0..N-1), then all imaginary words (address 0..N-1), where N = MATRIX_DIM*MATRIX_DIM.
- This is the same order and format used to load matrices A and B, so dumps can be compared directly against the loaded CSV format.
- Sits between the result RAM (synchronous, 1-cycle read latency) and the host/testbench capture logic.

---
 rtl/mat_result_unloader_if.sv | 29 ++
 rtl/mat_result_unloader.sv | 150 +++++++++++++++
 tb/tb_mat_result_unloader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_result_unloader_if.sv
// Bus bundle between the result unloader, the result RAM and the stream consumer.
// master: the unloader's own view. slave: the RAM/consumer side.
interface mat_result_unloader_if #(
   parameter int WORD_LEN  = 16,
   parameter int ADDR_BITS = 7
);
   logic                 start;
   logic                 busy;
   logic                 done;
   logic                 rd_en;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [WORD_LEN-1:0]  rd_data_real;
   logic [WORD_LEN-1:0]  rd_data_imag;
   logic [WORD_LEN-1:0]  out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_is_imag;
   logic                 out_last;

   modport master (
      input  start, rd_data_real, rd_data_imag, out_ready,
      output busy, done, rd_en, rd_addr, out_data, out_valid, out_is_imag, out_last
   );

   modport slave (
      output start, rd_data_real, rd_data_imag, out_ready,
      input  busy, done, rd_en, rd_addr, out_data, out_valid, out_is_imag, out_last
   );
endinterface

// File: rtl/mat_result_unloader.sv
// Result matrix unloader: reads all real words (addr 0..N-1), then all imaginary
// words (addr 0..N-1) from a 1-cycle-latency RAM and streams them over valid/ready
// through a 2-entry skid FIFO.
module mat_result_unloader #(
   parameter int WORD_LEN   = 16,
   parameter int MATRIX_DIM = 8,
   parameter int ADDR_BITS  = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   mat_result_unloader_if.master bus
);
   localparam int                   N         = MATRIX_DIM * MATRIX_DIM;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N - 1);
   localparam logic [ADDR_BITS:0]   LAST_WORD = (ADDR_BITS + 1)'(2 * N - 1);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_STREAM     = 2'd1;
   localparam logic [1:0] S_FLUSH_DONE = 2'd2;

   logic [1:0]           r_state;
   logic [ADDR_BITS-1:0] r_rd_addr;
   logic                 r_pass_imag;
   logic                 r_issue_done;
   logic                 r_inflight;
   logic                 r_inflight_imag;
   logic [WORD_LEN-1:0]  r_fifo_data [2];
   logic                 r_fifo_imag [2];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_count;
   logic [ADDR_BITS:0]   r_word_cnt;

   logic                 w_valid;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_issue;
   logic                 w_start_ok;
   logic                 w_stream_end;
   logic [2:0]           w_pending;
   logic [WORD_LEN-1:0]  w_push_data;

   assign w_valid      = (r_count != 2'd0);
   assign w_pop        = w_valid && bus.out_ready;
   assign w_push       = r_inflight;
   assign w_push_data  = r_inflight_imag ? bus.rd_data_imag : bus.rd_data_real;
   assign w_start_ok   = (r_state == S_IDLE) && bus.start;
   assign w_stream_end = w_pop && (r_word_cnt == LAST_WORD);

   // A word leaving this cycle frees its slot in time for a new read, which is
   // what allows one word per cycle while never exceeding two outstanding words.
   assign w_pending = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue   = (r_state == S_STREAM) && !r_issue_done && (w_pending < 3'd2);

   assign bus.busy        = (r_state == S_STREAM);
   assign bus.done        = (r_state == S_FLUSH_DONE);
   assign bus.rd_en       = w_issue;
   assign bus.rd_addr     = r_rd_addr;
   assign bus.out_valid   = w_valid;
   assign bus.out_data    = r_fifo_data[r_rd_ptr];
   assign bus.out_is_imag = w_valid && r_fifo_imag[r_rd_ptr];
   assign bus.out_last    = w_valid && (r_word_cnt == LAST_WORD);

   // Control FSM: idle -> stream until the last handshake -> one done cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:       if (bus.start) r_state <= S_STREAM;
            S_STREAM:     if (w_stream_end) r_state <= S_FLUSH_DONE;
            S_FLUSH_DONE: r_state <= S_IDLE;
            default:      r_state <= S_IDLE;
         endcase
      end
   end

   // Read address generator: REAL pass, wrap to IMAG pass, stop after IMAG N-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_addr    <= '0;
         r_pass_imag  <= 1'b0;
         r_issue_done <= 1'b0;
      end else if (w_start_ok) begin
         r_rd_addr    <= '0;
         r_pass_imag  <= 1'b0;
         r_issue_done <= 1'b0;
      end else if (w_issue) begin
         if (r_rd_addr == LAST_ADDR) begin
            r_rd_addr <= '0;
            if (r_pass_imag) r_issue_done <= 1'b1;
            else             r_pass_imag  <= 1'b1;
         end else begin
            r_rd_addr <= r_rd_addr + ADDR_BITS'(1);
         end
      end
   end

   // Track the read in flight and latch which RAM half it must be taken from.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inflight      <= 1'b0;
         r_inflight_imag <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_imag <= r_pass_imag;
      end
   end

   // Skid FIFO storage: returning RAM data is written with its pass tag.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_fifo_data[gi] <= '0;
            r_fifo_imag[gi] <= 1'b0;
         end else if (w_push && (r_wr_ptr == 1'(gi))) begin
            r_fifo_data[gi] <= w_push_data;
            r_fifo_imag[gi] <= r_inflight_imag;
         end
      end
   end

   // Skid FIFO pointers and occupancy; push+pop together leaves occupancy unchanged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Handshake counter: index of the word currently at the FIFO head.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word_cnt <= '0;
      end else if (w_start_ok) begin
         r_word_cnt <= '0;
      end else if (w_pop) begin
         r_word_cnt <= r_word_cnt + (ADDR_BITS + 1)'(1);
      end
   end
endmodule

// File: tb/tb_mat_result_unloader.sv
// Self-checking bench for mat_result_unloader: RAM model, stream capture and
// expected sequence computed directly from the RAM contents.
module tb_mat_result_unloader;
   localparam int N  = 64;
   localparam int NW = 2 * N;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mat_result_unloader_if #(.WORD_LEN(16), .ADDR_BITS(7)) bus ();

   mat_result_unloader #(.WORD_LEN(16), .MATRIX_DIM(8), .ADDR_BITS(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] ram_real [128];
   logic [15:0] ram_imag [128];

   // Synchronous RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_data_real <= ram_real[bus.rd_addr];
         bus.rd_data_imag <= ram_imag[bus.rd_addr];
      end
   end

   int checks   = 0;
   int failures = 0;

   logic [15:0] got_data [256];
   bit          got_imag [256];
   bit          got_last [256];
   int          got_cyc  [256];
   int          got_n, done_cnt, stable_err, outst_err, first_valid;
   int          issued_total, hold63, extra_words, busy_after;
   bit          rst_valid, rst_busy;

   function automatic logic [15:0] exp_word(input int i);
      return (i < N) ? ram_real[i] : ram_imag[i - N];
   endfunction

   // Number of captured words that differ from the expected stream.
   function automatic int count_bad(output int first_bad);
      int bad;
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < got_n && i < NW; i++) begin
         if (got_data[i] !== exp_word(i) || got_imag[i] !== (i >= N) ||
             got_last[i] !== (i == NW - 1)) begin
            if (first_bad < 0) first_bad = i;
            bad++;
         end
      end
      return bad;
   endfunction

   task automatic fill_pattern();
      for (int a = 0; a < 128; a++) begin
         ram_real[a] = 16'h0100 + 16'(a);
         ram_imag[a] = 16'h8000 + 16'(a);
      end
   endtask

   // Drives one dump and records everything the consumer saw.
   // mode 0: ready=1, 1: 1,0,0,1 pattern, 2: stall 10 cycles at word 63, 3: random.
   task automatic run_dump(input int mode, input int restart_at, input int reset_at);
      bit          prev_hold, restart_sent, r;
      logic [15:0] prev_data;
      bit          prev_imag, prev_last;
      int          stall_left, issued, accepted;
      bit          stall_used;
      got_n = 0; done_cnt = 0; stable_err = 0; outst_err = 0; first_valid = -1;
      hold63 = 0; extra_words = 0; issued = 0; accepted = 0;
      prev_hold = 0; prev_data = '0; prev_imag = 0; prev_last = 0;
      stall_left = 0; stall_used = 0; restart_sent = 0;
      for (int i = 0; i < 256; i++) begin
         got_data[i] = '0; got_imag[i] = 0; got_last[i] = 0; got_cyc[i] = 0;
      end
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int c = 0; c < 3000 && got_n < NW; c++) begin
         if (reset_at >= 0 && got_n == reset_at) begin
            rst = 1'b0;
            #1;
            rst_valid = bus.out_valid;
            rst_busy  = bus.busy;
            @(posedge clk); #1;
            rst = 1'b1;
            return;
         end
         case (mode)
            0: r = 1'b1;
            1: r = ((c % 4) == 0) || ((c % 4) == 3);
            2: begin
               if (bus.out_valid && got_n == 63 && !stall_used) begin
                  stall_left = 10;
                  stall_used = 1'b1;
               end
               r = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
            default: r = 1'($urandom_range(0, 1));
         endcase
         bus.out_ready = r;
         if (restart_at >= 0 && got_n == restart_at && !restart_sent) begin
            bus.start = 1'b1;
            restart_sent = 1'b1;
         end
         #1;
         if (bus.out_valid && first_valid < 0) first_valid = c;
         if (prev_hold && !(bus.out_valid && bus.out_data === prev_data &&
             bus.out_is_imag === prev_imag && bus.out_last === prev_last)) stable_err++;
         if (bus.done) done_cnt++;
         if (bus.rd_en) issued++;
         if (bus.out_valid && !r && got_n == 63) hold63++;
         prev_hold = bus.out_valid && !r;
         prev_data = bus.out_data;
         prev_imag = bus.out_is_imag;
         prev_last = bus.out_last;
         if (bus.out_valid && r) begin
            got_data[got_n] = bus.out_data;
            got_imag[got_n] = bus.out_is_imag;
            got_last[got_n] = bus.out_last;
            got_cyc[got_n]  = c;
            got_n++;
            accepted++;
         end
         if (issued - accepted > 2) outst_err++;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      bus.out_ready = 1'b1;
      for (int t = 0; t < 12; t++) begin
         #1;
         if (bus.done) done_cnt++;
         if (bus.rd_en) issued++;
         if (bus.out_valid) extra_words++;
         @(posedge clk); #1;
      end
      issued_total = issued;
      busy_after   = int'(bus.busy);
   endtask

   task automatic test_reset();
      rst = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
      checks++;
      if (bus.rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b required 0", bus.rd_en); end
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_is_imag, bus.done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: got valid/last/imag/done=%b%b%b%b required 0000",
                  bus.out_valid, bus.out_last, bus.out_is_imag, bus.done);
      end
      checks++;
      if (bus.rd_addr !== 7'd0 || bus.out_data !== 16'h0000) begin
         failures++;
         $display("FAIL reset_values: got rd_addr=%0h out_data=%0h required 0/0", bus.rd_addr, bus.out_data);
      end
      bus.start = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle: got busy=%b rd_en=%b valid=%b required 000", bus.busy, bus.rd_en, bus.out_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_rate();
      int bad, fb;
      fill_pattern();
      run_dump(0, -1, -1);
      bad = count_bad(fb);
      checks++;
      if (got_n !== NW) begin failures++; $display("FAIL full_count: got %0d required %0d", got_n, NW); end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL full_words: got %0d bad (first idx %0d) required 0", bad, fb); end
      checks++;
      if (got_data[0] !== 16'h0100 || got_data[63] !== 16'h013F) begin
         failures++; $display("FAIL full_real_ends: got %h,%h required 0100,013f", got_data[0], got_data[63]);
      end
      checks++;
      if (got_data[64] !== 16'h8000 || got_imag[64] !== 1'b1 || got_imag[63] !== 1'b0) begin
         failures++; $display("FAIL full_imag_start: got %h imag=%b required 8000 imag=1", got_data[64], got_imag[64]);
      end
      checks++;
      if (got_data[127] !== 16'h803F || got_last[127] !== 1'b1 || got_last[126] !== 1'b0) begin
         failures++; $display("FAIL full_last: got %h last=%b required 803f last=1", got_data[127], got_last[127]);
      end
      checks++;
      if (first_valid !== 2) begin failures++; $display("FAIL full_latency: got %0d required 2", first_valid); end
      checks++;
      if (got_cyc[127] - got_cyc[0] !== NW - 1) begin
         failures++; $display("FAIL full_throughput: got span %0d required %0d", got_cyc[127] - got_cyc[0], NW - 1);
      end
      checks++;
      if (done_cnt !== 1 || busy_after !== 0) begin
         failures++; $display("FAIL full_done: got done=%0d busy=%0d required 1/0", done_cnt, busy_after);
      end
      checks++;
      if (issued_total !== NW) begin failures++; $display("FAIL full_reads: got %0d required %0d", issued_total, NW); end
      $display("test_full_rate words=%0d done=%0d", got_n, done_cnt);
   endtask

   task automatic test_backpressure();
      int bad, fb;
      fill_pattern();
      run_dump(1, -1, -1);
      bad = count_bad(fb);
      checks++;
      if (got_n !== NW || bad !== 0) begin
         failures++; $display("FAIL bp_words: got n=%0d bad=%0d required %0d/0", got_n, bad, NW);
      end
      checks++;
      if (stable_err !== 0) begin failures++; $display("FAIL bp_stable: got %0d required 0", stable_err); end
      checks++;
      if (outst_err !== 0) begin failures++; $display("FAIL bp_outstanding: got %0d required 0", outst_err); end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
      $display("test_backpressure words=%0d", got_n);
   endtask

   task automatic test_pass_boundary();
      int bad, fb;
      fill_pattern();
      run_dump(2, -1, -1);
      bad = count_bad(fb);
      checks++;
      if (hold63 !== 10 || stable_err !== 0) begin
         failures++; $display("FAIL boundary_hold: got hold=%0d unstable=%0d required 10/0", hold63, stable_err);
      end
      checks++;
      if (got_data[63] !== 16'h013F || got_data[64] !== 16'h8000 || got_imag[64] !== 1'b1) begin
         failures++; $display("FAIL boundary_words: got %h,%h required 013f,8000", got_data[63], got_data[64]);
      end
      checks++;
      if (got_n !== NW || bad !== 0) begin
         failures++; $display("FAIL boundary_stream: got n=%0d bad=%0d required %0d/0", got_n, bad, NW);
      end
      $display("test_pass_boundary words=%0d hold=%0d", got_n, hold63);
   endtask

   task automatic test_start_during_busy();
      int bad, fb;
      fill_pattern();
      run_dump(0, 20, -1);
      bad = count_bad(fb);
      checks++;
      if (got_n !== NW || bad !== 0 || extra_words !== 0) begin
         failures++; $display("FAIL restart_words: got n=%0d bad=%0d extra=%0d required %0d/0/0", got_n, bad, extra_words, NW);
      end
      checks++;
      if (done_cnt !== 1 || busy_after !== 0) begin
         failures++; $display("FAIL restart_done: got done=%0d busy=%0d required 1/0", done_cnt, busy_after);
      end
      $display("test_start_during_busy words=%0d done=%0d", got_n, done_cnt);
   endtask

   task automatic test_reset_mid_dump();
      int bad, fb;
      fill_pattern();
      rst_valid = 1'b1; rst_busy = 1'b1;
      run_dump(0, -1, 40);
      checks++;
      if (rst_valid !== 1'b0 || rst_busy !== 1'b0) begin
         failures++; $display("FAIL midreset_outputs: got valid=%b busy=%b required 0/0", rst_valid, rst_busy);
      end
      run_dump(0, -1, -1);
      bad = count_bad(fb);
      checks++;
      if (got_data[0] !== 16'h0100) begin failures++; $display("FAIL midreset_first: got %h required 0100", got_data[0]); end
      checks++;
      if (got_n !== NW || bad !== 0 || done_cnt !== 1) begin
         failures++; $display("FAIL midreset_stream: got n=%0d bad=%0d done=%0d required %0d/0/1", got_n, bad, done_cnt, NW);
      end
      $display("test_reset_mid_dump words=%0d", got_n);
   endtask

   task automatic test_random();
      int bad, fb;
      for (int it = 0; it < 2; it++) begin
         for (int a = 0; a < 128; a++) begin
            ram_real[a] = 16'($urandom);
            ram_imag[a] = 16'($urandom);
         end
         run_dump(3, -1, -1);
         bad = count_bad(fb);
         checks++;
         if (got_n !== NW || bad !== 0) begin
            failures++; $display("FAIL rand_words: got n=%0d bad=%0d (first %0d) required %0d/0", got_n, bad, fb, NW);
         end
         checks++;
         if (stable_err !== 0 || outst_err !== 0 || done_cnt !== 1) begin
            failures++; $display("FAIL rand_protocol: got unstable=%0d outstanding=%0d done=%0d required 0/0/1", stable_err, outst_err, done_cnt);
         end
         $display("test_random iter=%0d words=%0d", it, got_n);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_full_rate();
      test_backpressure();
      test_pass_boundary();
      test_start_during_busy();
      test_reset_mid_dump();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
